// File: rtl/uart.sv
// Full-duplex 8N1 UART: RX/TX FIFOs behind a write-strobed register port; TX frames start 2 cycles after a write event.
// Writes to a full TX FIFO and bytes arriving at a full RX FIFO are dropped; define UART_LOOPBACK_EN to feed Tx into the receiver.

module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] dat_i,
  output logic [W-1:0] dat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dat_o   = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)                cnt_d = '0;
    else if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  // Flags are registered from the next count so they track the count with no extra lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      empty_o <= 1'b1;
      full_o  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      empty_o <= (cnt_d == '0);
      full_o  <= (cnt_d == (AW+1)'(DEPTH));
      if (flush_i) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (do_push) wr_q <= wr_q + 1'b1;
        if (do_pop)  rd_q <= rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= dat_i;
  end
endmodule

module uart #(
  parameter int CLKS_PER_BIT = 40,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Rx,
  input  logic [2:0] address,
  input  logic [7:0] w_data,
  input  logic       we,
  output logic [7:0] r_data,
  output logic       rx_empty,
  output logic       Tx,
  output logic       full
);
  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic we_q, wr_evt, tx_push, rx_pop, flush;
  logic rx_in, rx_push, rx_full;
  logic [7:0] rx_head, tx_head;
  logic tx_empty, tx_start;

  state_t        rx_state_q, tx_state_q;
  logic [CW-1:0] rx_cnt_q, tx_cnt_q;
  logic [2:0]    rx_idx_q, tx_idx_q;
  logic [7:0]    rx_shift_q, tx_shift_q;
  logic          tx_q;

  assign wr_evt  = we && !we_q;
  assign tx_push = wr_evt && !address[2];
  assign rx_pop  = wr_evt && (address == 3'd4);
  assign flush   = wr_evt && (address == 3'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) we_q <= 1'b0;
    else        we_q <= we;
  end

`ifdef UART_LOOPBACK_EN
  assign rx_in = tx_q;
`else
  logic rx_meta_q, rx_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_sync_q <= rx_meta_q;
    end
  end
  assign rx_in = rx_sync_q;
`endif

  // A good stop bit pushes in the sampling cycle, so rx_empty drops on the next edge.
  assign rx_push = (rx_state_q == S_STOP) && (rx_cnt_q == BIT_END) && rx_in && !rx_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        S_IDLE: if (!rx_in) begin
          rx_state_q <= S_START;
          rx_cnt_q   <= '0;
        end
        S_START: if (rx_cnt_q == HALF_END) begin
          rx_cnt_q   <= '0;
          rx_idx_q   <= '0;
          rx_state_q <= rx_in ? S_IDLE : S_DATA;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        S_DATA: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rx_in, rx_shift_q[7:1]};
          rx_idx_q   <= rx_idx_q + 1'b1;
          if (rx_idx_q == 3'd7) rx_state_q <= S_STOP;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        default: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q   <= '0;
          rx_state_q <= S_IDLE;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
      endcase
    end
  end

  // Reloading straight from the stop bit keeps queued frames contiguous.
  assign tx_start = !tx_empty &&
                    ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && (tx_cnt_q == BIT_END)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: if (tx_start) begin
          tx_shift_q <= tx_head;
          tx_q       <= 1'b0;
          tx_cnt_q   <= '0;
          tx_state_q <= S_START;
        end
        S_START: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q   <= '0;
          tx_idx_q   <= '0;
          tx_q       <= tx_shift_q[0];
          tx_state_q <= S_DATA;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        S_DATA: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q <= '0;
          tx_idx_q <= tx_idx_q + 1'b1;
          if (tx_idx_q == 3'd7) begin
            tx_q       <= 1'b1;
            tx_state_q <= S_STOP;
          end else begin
            tx_q       <= tx_shift_q[1];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
          end
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        default: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q <= '0;
          if (tx_start) begin
            tx_shift_q <= tx_head;
            tx_q       <= 1'b0;
            tx_state_q <= S_START;
          end else tx_state_q <= S_IDLE;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
      endcase
    end
  end

  assign Tx = tx_q;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .dat_i   (rx_shift_q),
    .dat_o   (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (tx_push),
    .pop_i   (tx_start),
    .dat_i   (w_data),
    .dat_o   (tx_head),
    .empty_o (tx_empty),
    .full_o  (full)
  );

  always_comb begin
    r_data = 8'h00;
    case (address)
      3'd0, 3'd1, 3'd2, 3'd3: if (!rx_empty) r_data = rx_head;
      3'd4:                   r_data = {6'b0, full, rx_empty};
      default:                r_data = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: RX vector table plus hand-written TX, reset, flush and error sequences.
`timescale 1ns/1ps
module tb_uart;
  localparam int CPB   = 40;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Rx;
  logic [2:0] address;
  logic [7:0] w_data;
  logic       we;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       Tx;
  logic       full;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_cnt = 0;

  uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Rx       (Rx),
    .address  (address),
    .w_data   (w_data),
    .we       (we),
    .r_data   (r_data),
    .rx_empty (rx_empty),
    .Tx       (Tx),
    .full     (full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #(600000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    w_data  = d;
    we      = 1'b1;
    @(negedge clk);
    we      = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    Rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      cyc(CPB);
    end
    Rx = stop;
    cyc(CPB);
    Rx = 1'b1;
  endtask

  task automatic get_frame(output logic [7:0] d, output logic ok, output int t);
    logic found, s0, s9;
    found = 1'b0;
    d = '0;
    t = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (Tx === 1'b0) found = 1'b1;
    end
    ok = found;
    if (found) begin
      t = cyc_cnt;
      cyc(CPB / 2);
      s0 = Tx;
      for (int i = 0; i < 8; i++) begin
        cyc(CPB);
        d[i] = Tx;
      end
      cyc(CPB);
      s9 = Tx;
      ok = (s0 === 1'b0) && (s9 === 1'b1);
    end
  endtask

  task automatic tx_quiet(input int n, output logic q);
    q = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (Tx !== 1'b1) q = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    logic       exp_empty;
    logic [7:0] exp_rd;
  } rxv_t;

  rxv_t       rxv [5];
  logic [7:0] burst [5];
  logic [7:0] tq [4];
  logic [7:0] fd [9];
  logic       fok [9];
  int         ft [9];
  logic       ok, q;
  logic [7:0] d;
  int         t;

  initial begin
    rxv[0] = '{8'h08, 1'b1, 1'b0, 8'h08};
    rxv[1] = '{8'hA5, 1'b1, 1'b0, 8'hA5};
    rxv[2] = '{8'h00, 1'b1, 1'b0, 8'h00};
    rxv[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF};
    rxv[4] = '{8'h2A, 1'b0, 1'b1, 8'h00};
    burst  = '{8'h08, 8'h07, 8'h2A, 8'h09, 8'h03};
    tq     = '{8'h01, 8'h09, 8'h00, 8'h08};

    rst_n = 1'b0; Rx = 1'b1; we = 1'b0; address = 3'd0; w_data = 8'h00;
    cyc(3);
    chk("reset_tx", Tx, 1);
    chk("reset_rx_empty", rx_empty, 1);
    chk("reset_full", full, 0);
    chk("reset_rdata", r_data, 8'h00);
    address = 3'd4; #1;
    chk("reset_status", r_data, 8'h01);
    rst_n = 1'b1;
    cyc(3);

`ifndef UART_LOOPBACK_EN
    for (int i = 0; i < 5; i++) begin
      send_rx(rxv[i].dat, rxv[i].stop);
      cyc(CPB);
      address = 3'd0; #1;
      chk($sformatf("rx_vec%0d_empty", i), rx_empty, rxv[i].exp_empty);
      chk($sformatf("rx_vec%0d_rdata", i), r_data, rxv[i].exp_rd);
      if (!rxv[i].exp_empty) begin
        wr(3'd4, 8'h00);
        chk($sformatf("rx_vec%0d_pop_empty", i), rx_empty, 1);
      end
    end

    for (int i = 0; i < 5; i++) send_rx(burst[i], 1'b1);
    cyc(CPB);
    for (int i = 0; i < 5; i++) begin
      address = 3'd1; #1;
      chk($sformatf("rx_burst%0d", i), r_data, burst[i]);
      wr(3'd4, 8'h00);
    end
    chk("rx_burst_drained", rx_empty, 1);

    Rx = 1'b0; cyc(10); Rx = 1'b1;
    cyc(3 * CPB);
    chk("rx_glitch_empty", rx_empty, 1);

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    cyc(10);
    chk("flush_pre_empty", rx_empty, 0);
    wr(3'd5, 8'h00);
    chk("flush_rx_empty", rx_empty, 1);
    address = 3'd0; #1;
    chk("flush_rdata", r_data, 8'h00);
`endif

    // Held strobe: one frame, start bit two cycles after the event.
    cyc(2);
    fork
      begin
        address = 3'd0; w_data = 8'h01; we = 1'b1;
        cyc(1);
        chk("held_tx_n1", Tx, 1);
        chk("held_full_n1", full, 0);
        cyc(1);
        chk("held_tx_n2", Tx, 0);
        cyc(CPB - 2);
        we = 1'b0;
      end
      get_frame(d, ok, t);
    join
    chk("held_frame_ok", ok, 1);
    chk("held_frame_data", d, 8'h01);
    tx_quiet(15 * CPB, q);
    chk("held_single_frame", q, 1);

    fork
      begin
        wr(3'd0, tq[0]); wr(3'd1, tq[1]); wr(3'd2, tq[2]); wr(3'd3, tq[3]);
      end
      for (int i = 0; i < 4; i++) get_frame(fd[i], fok[i], ft[i]);
    join
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("txq%0d_ok", i), fok[i], 1);
      chk($sformatf("txq%0d_data", i), fd[i], tq[i]);
      if (i > 0) chk($sformatf("txq%0d_gap", i), 16'(ft[i] - ft[i-1]), 16'(10 * CPB));
    end
    cyc(CPB);

    // First write is popped at once, so DEPTH+1 writes fill the FIFO.
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          wr(3'(i % 4), 8'h10 + 8'(i));
          if (i == 7) chk("fill_full_at7", full, 0);
          if (i == 8) chk("fill_full_at8", full, 1);
        end
        address = 3'd4; #1;
        chk("fill_status", r_data, {6'b0, 1'b1, rx_empty});
        wr(3'd0, 8'hEE);
        chk("fill_full_after_extra", full, 1);
      end
      for (int i = 0; i < 9; i++) get_frame(fd[i], fok[i], ft[i]);
    join
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("fill%0d_ok", i), fok[i], 1);
      chk($sformatf("fill%0d_data", i), fd[i], 8'h10 + 8'(i));
    end
    tx_quiet(15 * CPB, q);
    chk("fill_extra_dropped", q, 1);
    chk("fill_drained_full", full, 0);

`ifdef UART_LOOPBACK_EN
    wr(3'd0, 8'h2A);
    cyc(11 * CPB);
    address = 3'd0; #1;
    chk("loop_empty", rx_empty, 0);
    chk("loop_rdata", r_data, 8'h2A);
    wr(3'd4, 8'h00);
`else
    send_rx(8'h5A, 1'b1);
    cyc(5);
`endif
    wr(3'd0, 8'h55);
    wr(3'd0, 8'h66);
    cyc(100);
    address = 3'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", Tx, 1);
    chk("midrst_rx_empty", rx_empty, 1);
    chk("midrst_full", full, 0);
    chk("midrst_rdata", r_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tx_quiet(12 * CPB, q);
    chk("midrst_no_frame", q, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
